dmem_arbiter: RTL and testbench

Shared data-memory arbiter for the multicore processor. Sits between the per-core load/store ports and the single synchronous data RAM. Grants one core at a time, sequences a fixed four-cycle access per transaction, and returns read data and a completion pulse to the granted core. Round-robin by default; fixed priority is selectable at compile time.

---
 rtl/dmem_arbiter_if.sv | 36 +++
 rtl/dmem_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: core-side load/store bus plus the single-RAM port of the
// shared data-memory arbiter.
//   slave  : arbiter view (receives core requests, drives the RAM port)
//   master : environment view (cores issuing requests, RAM returning data)
interface dmem_arbiter_if #(
    parameter int NCORES = 4,
    parameter int AW     = 16,
    parameter int DW     = 16
);
    // Core side: requests in, grant/completion/read data out
    logic [NCORES-1:0]    req;
    logic [NCORES-1:0]    we;
    logic [NCORES*AW-1:0] addr;
    logic [NCORES*DW-1:0] wdata;
    logic [NCORES-1:0]    gnt;
    logic [NCORES-1:0]    done;
    logic [DW-1:0]        rdata;
    logic                 busy;

    // RAM side: one synchronous port, read data one cycle after mem_en
    logic                 mem_en;
    logic                 mem_we;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic [DW-1:0]        mem_rdata;

    modport slave (
        input  req, we, addr, wdata, mem_rdata,
        output gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, we, addr, wdata, mem_rdata,
        input  gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: grants one core at a time access to the shared synchronous
// data RAM. Each transaction runs IDLE -> ACCESS -> WAIT -> DONE -> IDLE:
// the winner's we/addr/wdata are captured at grant, the RAM is strobed for
// one cycle, read data is captured in WAIT and returned with a one-cycle
// done pulse. Grant stays high for the whole transaction.
//
// Compile-time option:
//   DMEM_ARB_FIXED_PRIO_EN defined   -> fixed priority, lowest index wins,
//                                       no round-robin pointer.
//   DMEM_ARB_FIXED_PRIO_EN undefined -> round-robin starting after the most
//                                       recent winner (core 0 first after reset).
module dmem_arbiter #(
    parameter int NCORES = 4,
    parameter int AW     = 16,
    parameter int DW     = 16
) (
    input  logic           clk,
    input  logic           RSTN,
    dmem_arbiter_if.slave  bus
);

    localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    state_e            state_q, state_d;

    // Winner and its captured request; the captured fields double as the
    // RAM port registers so they hold their value outside ACCESS.
    logic [IW-1:0]     win_q,       win_d;
    logic              mem_we_q,    mem_we_d;
    logic [AW-1:0]     mem_addr_q,  mem_addr_d;
    logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
    logic [DW-1:0]     rdata_q,     rdata_d;

    // Arbitration result for the current request vector
    logic              pick_vld;
    logic [IW-1:0]     pick_idx;
    logic              grant;

    // Decoded outputs
    logic [NCORES-1:0] gnt_o;
    logic [NCORES-1:0] done_o;
    logic              mem_en_o;
    logic              busy_o;

`ifdef DMEM_ARB_FIXED_PRIO_EN

    // Fixed priority: scan from the top so the lowest requesting index wins
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = NCORES - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                pick_vld = 1'b1;
                pick_idx = IW'(i);
            end
        end
    end

`else

    logic [IW-1:0]     last_q, last_d;
    logic [IW-1:0]     cand;

    // Round-robin: scan offsets NCORES..1 after last so offset 1 (nearest) wins
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = NCORES; i >= 1; i--) begin
            cand = IW'((int'(last_q) + i) % NCORES);
            if (bus.req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Pointer follows the most recent winner, updated on every grant
    always_comb begin
        last_d = last_q;
        if (grant) begin
            last_d = pick_idx;
        end
    end

    // Pointer register; reset value makes core 0 the first winner
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            last_q <= IW'(NCORES - 1);
        end else begin
            last_q <= last_d;
        end
    end

`endif

    // A grant is only decided from IDLE; other states ignore req
    assign grant = (state_q == ST_IDLE) && pick_vld;

    // FSM state register
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: fixed four-cycle walk once a grant is made
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (grant) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_WAIT;
            ST_WAIT:   state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: grant held ACCESS..DONE, RAM strobe in ACCESS, done in DONE
    always_comb begin
        gnt_o    = '0;
        done_o   = '0;
        mem_en_o = 1'b0;
        busy_o   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                busy_o = 1'b0;
            end
            ST_ACCESS: begin
                gnt_o[win_q] = 1'b1;
                mem_en_o     = 1'b1;
                busy_o       = 1'b1;
            end
            ST_WAIT: begin
                gnt_o[win_q] = 1'b1;
                busy_o       = 1'b1;
            end
            ST_DONE: begin
                gnt_o[win_q]  = 1'b1;
                done_o[win_q] = 1'b1;
                busy_o        = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

    // Datapath next state: capture winner's request at grant, read data in WAIT
    always_comb begin
        win_d       = win_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        if (grant) begin
            win_d       = pick_idx;
            mem_we_d    = bus.we[pick_idx];
            mem_addr_d  = bus.addr[int'(pick_idx) * AW +: AW];
            mem_wdata_d = bus.wdata[int'(pick_idx) * DW +: DW];
        end
        // Writes leave the last read value in place
        if ((state_q == ST_WAIT) && !mem_we_q) begin
            rdata_d = bus.mem_rdata;
        end
    end

    // Datapath registers; reset clears them so the RAM port idles at zero
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            win_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            win_q       <= win_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus.gnt       = gnt_o;
    assign bus.done      = done_o;
    assign bus.busy      = busy_o;
    assign bus.rdata     = rdata_q;
    assign bus.mem_en    = mem_en_o;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // Structural invariants: at most one grant, completion only to the grantee
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!RSTN)
        $onehot0(gnt_o));
    a_done_granted: assert property (@(posedge clk) disable iff (!RSTN)
        ((done_o & ~gnt_o) == '0));

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios followed by randomized transactions.
// A transaction-level model (arbitration rule, expected RAM contents,
// expected read data) predicts every grant, RAM access and completion.
module tb_dmem_arbiter;

    localparam int NCORES = 4;
    localparam int AW     = 16;
    localparam int DW     = 16;

    logic clk = 1'b0;
    logic RSTN;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.NCORES(NCORES), .AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(.NCORES(NCORES), .AW(AW), .DW(DW)) dut (
        .clk  (clk),
        .RSTN (RSTN),
        .bus  (bus)
    );

    // Simple synchronous RAM, 256 words, read data one cycle after mem_en
    logic [DW-1:0] ram [0:255];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
            else            bus.mem_rdata <= ram[bus.mem_addr[7:0]];
        end
    end

    // Count RAM strobes, sampled on the inactive edge
    int en_cnt = 0;
    always @(negedge clk) begin
        if (bus.mem_en) en_cnt++;
    end

    // Per-core request state driven by the bench
    logic [NCORES-1:0] req_v;
    logic              c_we   [NCORES];
    logic [AW-1:0]     c_addr [NCORES];
    logic [DW-1:0]     c_wd   [NCORES];

    // Reference model state
    logic [DW-1:0]     ref_mem [0:255];
    logic [DW-1:0]     exp_rdata;
    int                model_last;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        for (int i = 0; i < NCORES; i++) begin
            bus.req[i]              = req_v[i];
            bus.we[i]               = c_we[i];
            bus.addr[i*AW +: AW]    = c_addr[i];
            bus.wdata[i*DW +: DW]   = c_wd[i];
        end
    endtask

    // Arbitration rule of the model
    function automatic int pick(input logic [NCORES-1:0] r);
`ifdef DMEM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NCORES; i++) if (r[i]) return i;
`else
        for (int s = 1; s <= NCORES; s++) begin
            if (r[(model_last + s) % NCORES]) return (model_last + s) % NCORES;
        end
`endif
        return 0;
    endfunction

    task automatic model_reset();
        model_last = NCORES - 1;
        exp_rdata  = '0;
    endtask

    // One complete transaction, called in an IDLE cycle with req_v nonzero
    task automatic run_txn(output int w);
        int            ew;
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        ew = pick(req_v);
        wr = c_we[ew];
        a  = c_addr[ew];
        d  = c_wd[ew];
        tick();
        chk("gnt_access", 32'(bus.gnt), 32'(1) << ew);
        chk("mem_en_access", 32'(bus.mem_en), 32'd1);
        chk("mem_we", 32'(bus.mem_we), 32'(wr));
        chk("mem_addr", 32'(bus.mem_addr), 32'(a));
        chk("mem_wdata", 32'(bus.mem_wdata), 32'(d));
        chk("busy_access", 32'(bus.busy), 32'd1);
        chk("done_access", 32'(bus.done), 32'd0);
        // Winner changes its inputs mid-transaction; RAM must not see it
        c_addr[ew] = (a + 16'd4) & 16'h00FF;
        c_wd[ew]   = ~d;
        drive();
        tick();
        chk("mem_en_wait", 32'(bus.mem_en), 32'd0);
        chk("gnt_wait", 32'(bus.gnt), 32'(1) << ew);
        chk("mem_addr_hold", 32'(bus.mem_addr), 32'(a));
        chk("done_wait", 32'(bus.done), 32'd0);
        tick();
        if (wr) ref_mem[a[7:0]] = d;
        else    exp_rdata = ref_mem[a[7:0]];
        chk("done_pulse", 32'(bus.done), 32'(1) << ew);
        chk("gnt_done", 32'(bus.gnt), 32'(1) << ew);
        chk("rdata", 32'(bus.rdata), 32'(exp_rdata));
        model_last = ew;
        req_v[ew] = 1'b0;
        drive();
        tick();
        chk("gnt_idle", 32'(bus.gnt), 32'd0);
        chk("done_idle", 32'(bus.done), 32'd0);
        chk("busy_idle", 32'(bus.busy), 32'd0);
        w = ew;
    endtask

    int exp_order [5];
    int w;
    int base;
    int c;

    initial begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        bus.mem_rdata = '0;
        model_reset();

        // Reset with every core requesting: nothing is granted
        RSTN = 1'b0;
        req_v = '1;
        for (int i = 0; i < NCORES; i++) begin
            c_we[i]   = 1'b1;
            c_addr[i] = 16'($urandom_range(255));
            c_wd[i]   = 16'($urandom);
        end
        drive();
        repeat (3) tick();
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);

        // Release with all cores requesting, each re-requesting after done
        RSTN = 1'b1;
        for (int k = 0; k < 5; k++) begin
            run_txn(w);
            chk("rr_order", 32'(w), 32'(exp_order[k]));
            req_v[w] = 1'b1;
            drive();
        end
        req_v = '0;
        drive();
        tick();

        // Core 2 writes 35 to 0x10, then reads it back
        req_v = 4'b0100; c_we[2] = 1'b1; c_addr[2] = 16'h0010; c_wd[2] = 16'd35;
        drive();
        run_txn(w);
        req_v = 4'b0100; c_we[2] = 1'b0; c_addr[2] = 16'h0010;
        drive();
        run_txn(w);
        chk("rd_35", 32'(bus.rdata), 32'd35);

        // Core 1 writes 0x0004 while changing its address to 0x0008 in ACCESS
        req_v = 4'b0010; c_we[1] = 1'b1; c_addr[1] = 16'h0004; c_wd[1] = 16'hBEEF;
        drive();
        run_txn(w);
        req_v = 4'b0010; c_we[1] = 1'b0; c_addr[1] = 16'h0004;
        drive();
        run_txn(w);
        chk("rd_stable", 32'(bus.rdata), 32'h0000BEEF);

        // Core 3 read aborted by reset during WAIT
        req_v = 4'b1000; c_we[3] = 1'b0; c_addr[3] = 16'h0010;
        drive();
        tick();
        chk("mid_gnt", 32'(bus.gnt), 32'b1000);
        tick();
        chk("mid_wait_en", 32'(bus.mem_en), 32'd0);
        RSTN = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_gnt", 32'(bus.gnt), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_rdata", 32'(bus.rdata), 32'd0);
        repeat (2) begin
            tick();
            chk("mid_rst_done", 32'(bus.done), 32'd0);
        end
        req_v = 4'b1001; c_we[0] = 1'b0; c_addr[0] = 16'h0010;
        drive();
        RSTN = 1'b1;
        run_txn(w);
        chk("post_rst_winner", 32'(w), 32'd0);
        run_txn(w);
        chk("post_rst_second", 32'(w), 32'd3);

        // Idle for 20 cycles: never busy, never a RAM strobe
        req_v = '0;
        drive();
        base = en_cnt;
        repeat (20) begin
            tick();
            chk("idle_busy", 32'(bus.busy), 32'd0);
        end
        chk("idle_mem_en_cnt", 32'(en_cnt - base), 32'd0);

        // Fill the RAM so every later read has a known value
        for (int a = 0; a < 256; a++) begin
            c = a % NCORES;
            req_v = '0;
            req_v[c] = 1'b1;
            c_we[c] = 1'b1;
            c_addr[c] = 16'(a);
            c_wd[c] = 16'($urandom);
            drive();
            run_txn(w);
        end

        // Random contending traffic
        req_v = '0;
        for (int it = 0; it < 150; it++) begin
            if (req_v == '0 && $urandom_range(7) == 0) begin
                repeat ($urandom_range(4, 1)) begin
                    tick();
                    chk("gap_busy", 32'(bus.busy), 32'd0);
                end
            end
            for (int i = 0; i < NCORES; i++) begin
                if (!req_v[i] && $urandom_range(1) == 1) begin
                    req_v[i]  = 1'b1;
                    c_we[i]   = 1'($urandom_range(1));
                    c_addr[i] = 16'($urandom_range(255));
                    c_wd[i]   = 16'($urandom);
                end
            end
            if (req_v == '0) begin
                c = $urandom_range(NCORES - 1);
                req_v[c]  = 1'b1;
                c_we[c]   = 1'($urandom_range(1));
                c_addr[c] = 16'($urandom_range(255));
                c_wd[c]   = 16'($urandom);
            end
            drive();
            run_txn(w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
